// File: rtl/occ_pkg.sv
// occ_pkg: shared door-state encoding and event popcount for the occupancy counter
package occ_pkg;
  typedef enum logic [1:0] {IDLE, SEEN1, SEEN2, WAIT_CLR} door_state_t;
  function automatic logic [3:0] popcount(input logic [7:0] v);
    logic [3:0] c;
    c = '0;
    for (int i = 0; i < 8; i++) c = c + {3'b0, v[i]};
    return c;
  endfunction
endpackage

// File: rtl/occ_door_fsm.sv
// occ_door_fsm: one door's direction FSM, abort timer and entry/exit event decode
module occ_door_fsm
  import occ_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic s1,
  input  logic s2,
  output logic ev_entry,
  output logic ev_exit,
  output logic entry,
  output logic exit_o
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  door_state_t r_state, w_nxt_state;
  logic [TW-1:0] r_timer, w_nxt_timer;
  logic r_entry, r_exit;
  assign ev_entry = (r_state == SEEN1) && s2;
  assign ev_exit = (r_state == SEEN2) && s1;
  assign entry = r_entry;
  assign exit_o = r_exit;
  // next state: a half pass survives TIMEOUT idle cycles, then is dropped
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_timer = r_timer;
    case (r_state)
      IDLE: begin
        w_nxt_state = (s1 && !s2) ? SEEN1 : (s2 && !s1) ? SEEN2 : IDLE;
        w_nxt_timer = '0;
      end
      SEEN1: begin
        w_nxt_state = s2 ? WAIT_CLR : (r_timer == TMAX) ? IDLE : SEEN1;
        w_nxt_timer = (s2 || r_timer == TMAX) ? r_timer : r_timer + 1'b1;
      end
      SEEN2: begin
        w_nxt_state = s1 ? WAIT_CLR : (r_timer == TMAX) ? IDLE : SEEN2;
        w_nxt_timer = (s1 || r_timer == TMAX) ? r_timer : r_timer + 1'b1;
      end
      default: w_nxt_state = (!s1 && !s2) ? IDLE : WAIT_CLR;
    endcase
  end
  // state, timer and one-cycle event pulses; clr aborts the pass and suppresses pulses
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_entry <= 1'b0;
      r_exit <= 1'b0;
    end else if (clr) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_entry <= 1'b0;
      r_exit <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_timer <= w_nxt_timer;
      r_entry <= ev_entry;
      r_exit <= ev_exit;
    end
  end
endmodule

// File: rtl/occ_counter_multi.sv
// occ_counter_multi: N-door room occupancy counter with saturation, status and sticky errors
module occ_counter_multi
  import occ_pkg::*;
#(
  parameter int N_DOORS = 2,
  parameter int CNT_W = 6,
  parameter int CAPACITY = 40,
  parameter int TIMEOUT = 15
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_DOORS-1:0] s1,
  input  logic [N_DOORS-1:0] s2,
  input  logic               clr,
  output logic [CNT_W-1:0]   count,
  output logic               light,
  output logic               full,
  output logic               empty,
  output logic [N_DOORS-1:0] entry,
  output logic [N_DOORS-1:0] exit_o,
  output logic               ovf_err,
  output logic               unf_err
);
  localparam int SW = CNT_W + 4;
  localparam logic signed [SW-1:0] CAP_S = SW'(CAPACITY);
  logic [N_DOORS-1:0] w_ev_in, w_ev_out;
  logic [3:0] w_e, w_x;
  logic signed [SW-1:0] w_nxt;
  logic w_ovf, w_unf;
  logic [CNT_W-1:0] r_count;
  logic r_ovf, r_unf;
  for (genvar d = 0; d < N_DOORS; d++) begin : g_door
    occ_door_fsm #(.TIMEOUT(TIMEOUT)) u_door (
      .clock(clock),
      .reset(reset),
      .clr(clr),
      .s1(s1[d]),
      .s2(s2[d]),
      .ev_entry(w_ev_in[d]),
      .ev_exit(w_ev_out[d]),
      .entry(entry[d]),
      .exit_o(exit_o[d])
    );
  end
  assign w_e = popcount(8'(w_ev_in));
  assign w_x = popcount(8'(w_ev_out));
  assign w_nxt = SW'(r_count) + SW'(w_e) - SW'(w_x);
  assign w_unf = w_nxt[SW-1];
  assign w_ovf = w_nxt > CAP_S;
  assign count = r_count;
  assign light = r_count != '0;
  assign empty = r_count == '0;
  assign full = r_count == CNT_W'(CAPACITY);
  assign ovf_err = r_ovf;
  assign unf_err = r_unf;
  // net entries minus exits per cycle, clamped to [0, CAPACITY] with sticky loss flags
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (clr) begin
      r_count <= '0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_count <= w_unf ? '0 : w_ovf ? CNT_W'(CAPACITY) : w_nxt[CNT_W-1:0];
      r_ovf <= r_ovf | w_ovf;
      r_unf <= r_unf | w_unf;
    end
  end
endmodule

// File: tb/tb_occ_counter_multi.sv
// tb_occ_counter_multi: directed checks of door sequencing, timeout, saturation, clr and reset
module tb_occ_counter_multi;
  logic clock = 1'b0;
  logic reset = 1'b0;
  logic clr = 1'b0;
  logic [1:0] s1a = '0, s2a = '0, s1b = '0, s2b = '0;
  logic [5:0] cnt_a, cnt_b;
  logic light_a, full_a, empty_a, ovf_a, unf_a;
  logic light_b, full_b, empty_b, ovf_b, unf_b;
  logic [1:0] ent_a, ext_a, ent_b, ext_b;
  int n_chk = 0;
  int n_fail = 0;
  int n_pulse;
  always #5 clock = ~clock;
  occ_counter_multi #(.N_DOORS(2), .CNT_W(6), .CAPACITY(5), .TIMEOUT(15)) dut (
    .clock(clock), .reset(reset), .s1(s1a), .s2(s2a), .clr(clr),
    .count(cnt_a), .light(light_a), .full(full_a), .empty(empty_a),
    .entry(ent_a), .exit_o(ext_a), .ovf_err(ovf_a), .unf_err(unf_a)
  );
  occ_counter_multi #(.N_DOORS(2), .CNT_W(6), .CAPACITY(3), .TIMEOUT(15)) dut3 (
    .clock(clock), .reset(reset), .s1(s1b), .s2(s2b), .clr(clr),
    .count(cnt_b), .light(light_b), .full(full_b), .empty(empty_b),
    .entry(ent_b), .exit_o(ext_b), .ovf_err(ovf_b), .unf_err(unf_b)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask
  task automatic drv_a(input logic [1:0] a1, input logic [1:0] a2);
    s1a = a1;
    s2a = a2;
    cyc();
  endtask
  task automatic drv_b(input logic [1:0] b1, input logic [1:0] b2);
    s1b = b1;
    s2b = b2;
    cyc();
  endtask
  initial begin
    repeat (2) cyc();
    check("rst_count", 32'(cnt_a), 0);
    check("rst_light", 32'(light_a), 0);
    check("rst_full", 32'(full_a), 0);
    check("rst_empty", 32'(empty_a), 1);
    check("rst_pulses", 32'({ent_a, ext_a}), 0);
    check("rst_err", 32'({ovf_a, unf_a}), 0);
    reset = 1'b1;
    cyc();
    drv_a(2'b01, 2'b00);
    check("ent_early", 32'(ent_a), 0);
    drv_a(2'b01, 2'b01);
    check("ent_count", 32'(cnt_a), 1);
    check("ent_pulse", 32'(ent_a), 2'b01);
    check("ent_light", 32'(light_a), 1);
    check("ent_empty", 32'(empty_a), 0);
    drv_a(2'b01, 2'b01);
    check("ent_pulse_once", 32'(ent_a), 0);
    n_pulse = 0;
    for (int i = 0; i < 11; i++) begin
      drv_a(2'b00, 2'b01);
      if (ent_a != 0 || ext_a != 0) n_pulse++;
    end
    drv_a(2'b00, 2'b00);
    check("hold_s2_pulses", 32'(n_pulse), 0);
    check("hold_s2_count", 32'(cnt_a), 1);
    drv_a(2'b00, 2'b10);
    drv_a(2'b10, 2'b10);
    check("exit_count", 32'(cnt_a), 0);
    check("exit_pulse", 32'(ext_a), 2'b10);
    check("exit_empty", 32'(empty_a), 1);
    check("exit_no_unf", 32'(unf_a), 0);
    drv_a(2'b00, 2'b00);
    check("exit_pulse_once", 32'(ext_a), 0);
    drv_a(2'b00, 2'b10);
    drv_a(2'b10, 2'b10);
    drv_a(2'b00, 2'b00);
    check("unf_count", 32'(cnt_a), 0);
    check("unf_flag", 32'(unf_a), 1);
    drv_a(2'b01, 2'b00);
    s1a = 2'b00;
    repeat (15) cyc();
    drv_a(2'b00, 2'b01);
    check("tmo_last_ok", 32'(ent_a), 2'b01);
    check("tmo_last_cnt", 32'(cnt_a), 1);
    drv_a(2'b00, 2'b00);
    drv_a(2'b01, 2'b00);
    s1a = 2'b00;
    repeat (16) cyc();
    drv_a(2'b00, 2'b01);
    check("tmo_late_ent", 32'(ent_a), 0);
    check("tmo_late_cnt", 32'(cnt_a), 1);
    s2a = 2'b00;
    repeat (17) cyc();
    n_pulse = 0;
    for (int i = 0; i < 17; i++) begin
      drv_a(2'b01, 2'b00);
      if (ent_a != 0) n_pulse++;
    end
    drv_a(2'b00, 2'b00);
    drv_a(2'b00, 2'b01);
    if (ent_a != 0 || ext_a != 0) n_pulse++;
    s2a = 2'b00;
    repeat (17) cyc();
    check("tmo_held_pulses", 32'(n_pulse), 0);
    check("tmo_held_cnt", 32'(cnt_a), 1);
    drv_a(2'b11, 2'b00);
    drv_a(2'b11, 2'b11);
    check("dual_cnt3", 32'(cnt_a), 3);
    check("dual_pulse", 32'(ent_a), 2'b11);
    drv_a(2'b00, 2'b00);
    drv_a(2'b11, 2'b00);
    drv_a(2'b11, 2'b11);
    drv_a(2'b00, 2'b00);
    check("a_full5", 32'(full_a), 1);
    check("a_no_ovf", 32'(ovf_a), 0);
    drv_a(2'b11, 2'b00);
    drv_a(2'b11, 2'b11);
    drv_a(2'b00, 2'b00);
    check("a_sat_cnt", 32'(cnt_a), 5);
    check("a_ovf", 32'(ovf_a), 1);
    drv_b(2'b11, 2'b00);
    drv_b(2'b11, 2'b11);
    drv_b(2'b00, 2'b00);
    check("b_cnt2", 32'(cnt_b), 2);
    check("b_not_full", 32'(full_b), 0);
    drv_b(2'b11, 2'b00);
    drv_b(2'b11, 2'b11);
    check("b_sat_cnt", 32'(cnt_b), 3);
    check("b_full", 32'(full_b), 1);
    check("b_ovf", 32'(ovf_b), 1);
    drv_b(2'b00, 2'b00);
    drv_b(2'b01, 2'b10);
    drv_b(2'b11, 2'b11);
    check("b_net_cnt", 32'(cnt_b), 3);
    check("b_net_pulses", 32'({ent_b, ext_b}), 4'b0110);
    check("b_net_unf", 32'(unf_b), 0);
    drv_b(2'b00, 2'b00);
    drv_a(2'b01, 2'b10);
    s2a = 2'b11;
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    check("clr_cnt", 32'(cnt_a), 0);
    check("clr_err", 32'({ovf_a, unf_a}), 0);
    check("clr_pulse", 32'(ent_a), 0);
    check("clr_b_cnt", 32'(cnt_b), 0);
    check("clr_b_ovf", 32'(ovf_b), 0);
    drv_a(2'b10, 2'b00);
    check("clr_fsm_exit", 32'(ext_a), 0);
    check("clr_fsm_unf", 32'(unf_a), 0);
    check("clr_fsm_ent", 32'(ent_a), 0);
    s1a = 2'b00;
    repeat (17) cyc();
    drv_b(2'b01, 2'b10);
    drv_b(2'b11, 2'b11);
    check("b_zero_net_cnt", 32'(cnt_b), 0);
    check("b_zero_net_unf", 32'(unf_b), 0);
    drv_b(2'b00, 2'b00);
    drv_a(2'b01, 2'b00);
    s2a = 2'b01;
    reset = 1'b0;
    #1;
    check("rstmid_cnt", 32'(cnt_a), 0);
    repeat (2) cyc();
    reset = 1'b1;
    cyc();
    check("rstrel_pulse", 32'(ent_a), 0);
    drv_a(2'b01, 2'b01);
    drv_a(2'b01, 2'b01);
    check("rstrel_cnt", 32'(cnt_a), 0);
    check("rstrel_ent", 32'(ent_a), 0);
    drv_a(2'b00, 2'b00);
    drv_a(2'b01, 2'b00);
    drv_a(2'b01, 2'b01);
    check("fresh_ent", 32'(ent_a), 2'b01);
    check("fresh_cnt", 32'(cnt_a), 1);
    drv_a(2'b00, 2'b00);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
